// File: rtl/warp_dmem_arbiter_if.sv
// Bundle of the core-side LSU channels and the external data-memory channels for warp_dmem_arbiter.
// master = the arbiter, slave = the core LSUs plus the data memory.
interface warp_dmem_arbiter_if #(
   parameter int ADDR_BITS         = 8,
   parameter int DATA_BITS         = 8,
   parameter int THREADS_PER_BLOCK = 4,
   parameter int NUM_CHANNELS      = 2
);
   localparam int NC = 2 * THREADS_PER_BLOCK;

   logic [NC-1:0]                          consumer_read_valid;
   logic [NC-1:0][ADDR_BITS-1:0]           consumer_read_address;
   logic [NC-1:0]                          consumer_read_ready;
   logic [NC-1:0][DATA_BITS-1:0]           consumer_read_data;
   logic [NC-1:0]                          consumer_write_valid;
   logic [NC-1:0][ADDR_BITS-1:0]           consumer_write_address;
   logic [NC-1:0][DATA_BITS-1:0]           consumer_write_data;
   logic [NC-1:0]                          consumer_write_ready;

   logic [NUM_CHANNELS-1:0]                mem_read_valid;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
   logic [NUM_CHANNELS-1:0]                mem_read_ready;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;
   logic [NUM_CHANNELS-1:0]                mem_write_valid;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
   logic [NUM_CHANNELS-1:0]                mem_write_ready;

   modport master (
      input  consumer_read_valid, consumer_read_address,
      input  consumer_write_valid, consumer_write_address, consumer_write_data,
      output consumer_read_ready, consumer_read_data, consumer_write_ready,
      output mem_read_valid, mem_read_address,
      output mem_write_valid, mem_write_address, mem_write_data,
      input  mem_read_ready, mem_read_data, mem_write_ready
   );

   modport slave (
      output consumer_read_valid, consumer_read_address,
      output consumer_write_valid, consumer_write_address, consumer_write_data,
      input  consumer_read_ready, consumer_read_data, consumer_write_ready,
      input  mem_read_valid, mem_read_address,
      input  mem_write_valid, mem_write_address, mem_write_data,
      output mem_read_ready, mem_read_data, mem_write_ready
   );
endinterface

// File: rtl/warp_dmem_arbiter.sv
// Round-robin arbiter from 2*THREADS_PER_BLOCK warp LSU consumers onto NUM_CHANNELS data-memory channels.
// Optional macro WARP_DMEM_ARB_PRIORITY_EN adds priority_warp to search the preferred warp first.
module warp_dmem_arbiter #(
   parameter int ADDR_BITS         = 8,
   parameter int DATA_BITS         = 8,
   parameter int THREADS_PER_BLOCK = 4,
   parameter int NUM_CHANNELS      = 2
) (
   input logic                 clk,
   input logic                 reset,
   warp_dmem_arbiter_if.master bus
`ifdef WARP_DMEM_ARB_PRIORITY_EN
   ,
   input logic                 priority_warp
`endif
);
   localparam int NC = 2 * THREADS_PER_BLOCK;
   localparam int IW = (NC > 1) ? $clog2(NC) : 1;
`ifdef WARP_DMEM_ARB_PRIORITY_EN
   localparam int NUM_PASSES = 2;
`else
   localparam int NUM_PASSES = 1;
`endif

   typedef enum logic [2:0] {
      IDLE,
      READ_WAITING,
      WRITE_WAITING,
      READ_RELAYING,
      WRITE_RELAYING
   } state_e;

   state_e                                 state_q [NUM_CHANNELS];
   logic [IW-1:0]                          owner_q [NUM_CHANNELS];
   logic [NC-1:0]                          busy_q;
   logic [IW-1:0]                          rrPtr_q;
   logic [NUM_CHANNELS-1:0]                memReadValid_q;
   logic [NUM_CHANNELS-1:0]                memWriteValid_q;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] memReadAddress_q;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] memWriteAddress_q;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] memWriteData_q;
   logic [NC-1:0]                          consumerReadReady_q;
   logic [NC-1:0]                          consumerWriteReady_q;
   logic [NC-1:0][DATA_BITS-1:0]           consumerReadData_q;

   logic [NC-1:0]                          pending;
   logic [NC-1:0]                          taken;
   logic [NUM_CHANNELS-1:0]                grantValid;
   logic [NUM_CHANNELS-1:0]                grantRead;
   logic [IW-1:0]                          grantIdx [NUM_CHANNELS];
   logic                                   anyGrant;
   logic [IW-1:0]                          lastGrant;
   logic [IW-1:0]                          candIdx;
   logic                                   candMatch;
   logic [IW-1:0]                          rrPtr_d;

   function automatic logic [IW-1:0] wrapIdx(input logic [IW-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NC) sum = sum - NC;
      return IW'(sum);
   endfunction

   assign pending = bus.consumer_read_valid | bus.consumer_write_valid;

   // Channels claim consumers in index order; a consumer already owned or claimed
   // by a lower channel this cycle is skipped, so no consumer ever has two channels.
   always_comb begin
      taken      = busy_q;
      grantValid = '0;
      grantRead  = '0;
      anyGrant   = 1'b0;
      lastGrant  = '0;
      candIdx    = '0;
      candMatch  = 1'b0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) grantIdx[ch] = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (state_q[ch] == IDLE) begin
            for (int pass = 0; pass < NUM_PASSES; pass++) begin
               for (int k = 0; k < NC; k++) begin
                  candIdx = wrapIdx(rrPtr_q, k);
`ifdef WARP_DMEM_ARB_PRIORITY_EN
                  candMatch = ((candIdx >= IW'(THREADS_PER_BLOCK)) ==
                               ((pass == 0) ? priority_warp : ~priority_warp));
`else
                  candMatch = (pass == 0);
`endif
                  if (!grantValid[ch] && candMatch && pending[candIdx] && !taken[candIdx]) begin
                     grantValid[ch] = 1'b1;
                     grantIdx[ch]   = candIdx;
                     grantRead[ch]  = bus.consumer_read_valid[candIdx];
                  end
               end
            end
            if (grantValid[ch]) begin
               taken[grantIdx[ch]] = 1'b1;
               anyGrant            = 1'b1;
               lastGrant           = grantIdx[ch];
            end
         end
      end
   end

   // The last grant of a cycle is the furthest from rrPtr in wrap order, so the
   // pointer resumes just past it (7 then 0 granted moves the pointer to 1).
   assign rrPtr_d = (lastGrant == IW'(NC - 1)) ? '0 : lastGrant + 1'b1;

   // Per-channel FSMs plus all registered outputs; reset abandons in-flight requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_q[ch] <= IDLE;
            owner_q[ch] <= '0;
         end
         busy_q               <= '0;
         rrPtr_q              <= '0;
         memReadValid_q       <= '0;
         memWriteValid_q      <= '0;
         memReadAddress_q     <= '0;
         memWriteAddress_q    <= '0;
         memWriteData_q       <= '0;
         consumerReadReady_q  <= '0;
         consumerWriteReady_q <= '0;
         consumerReadData_q   <= '0;
      end else begin
         if (anyGrant) rrPtr_q <= rrPtr_d;
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state_q[ch])
               IDLE: begin
                  if (grantValid[ch]) begin
                     owner_q[ch]         <= grantIdx[ch];
                     busy_q[grantIdx[ch]] <= 1'b1;
                     if (grantRead[ch]) begin
                        memReadValid_q[ch]   <= 1'b1;
                        memReadAddress_q[ch] <= bus.consumer_read_address[grantIdx[ch]];
                        state_q[ch]          <= READ_WAITING;
                     end else begin
                        memWriteValid_q[ch]   <= 1'b1;
                        memWriteAddress_q[ch] <= bus.consumer_write_address[grantIdx[ch]];
                        memWriteData_q[ch]    <= bus.consumer_write_data[grantIdx[ch]];
                        state_q[ch]           <= WRITE_WAITING;
                     end
                  end
               end
               READ_WAITING: begin
                  if (bus.mem_read_ready[ch]) begin
                     consumerReadData_q[owner_q[ch]]  <= bus.mem_read_data[ch];
                     consumerReadReady_q[owner_q[ch]] <= 1'b1;
                     memReadValid_q[ch]               <= 1'b0;
                     memReadAddress_q[ch]             <= '0;
                     state_q[ch]                      <= READ_RELAYING;
                  end
               end
               WRITE_WAITING: begin
                  if (bus.mem_write_ready[ch]) begin
                     consumerWriteReady_q[owner_q[ch]] <= 1'b1;
                     memWriteValid_q[ch]               <= 1'b0;
                     memWriteAddress_q[ch]             <= '0;
                     memWriteData_q[ch]                <= '0;
                     state_q[ch]                       <= WRITE_RELAYING;
                  end
               end
               READ_RELAYING: begin
                  if (!bus.consumer_read_valid[owner_q[ch]]) begin
                     consumerReadReady_q[owner_q[ch]] <= 1'b0;
                     busy_q[owner_q[ch]]              <= 1'b0;
                     state_q[ch]                      <= IDLE;
                  end
               end
               WRITE_RELAYING: begin
                  if (!bus.consumer_write_valid[owner_q[ch]]) begin
                     consumerWriteReady_q[owner_q[ch]] <= 1'b0;
                     busy_q[owner_q[ch]]               <= 1'b0;
                     state_q[ch]                       <= IDLE;
                  end
               end
               default: state_q[ch] <= IDLE;
            endcase
         end
      end
   end

   assign bus.consumer_read_ready  = consumerReadReady_q;
   assign bus.consumer_read_data   = consumerReadData_q;
   assign bus.consumer_write_ready = consumerWriteReady_q;
   assign bus.mem_read_valid       = memReadValid_q;
   assign bus.mem_read_address     = memReadAddress_q;
   assign bus.mem_write_valid      = memWriteValid_q;
   assign bus.mem_write_address    = memWriteAddress_q;
   assign bus.mem_write_data       = memWriteData_q;
endmodule

// File: tb/tb_warp_dmem_arbiter.sv
// Directed testbench for warp_dmem_arbiter with T=4, C=2 and a fixed 3-cycle data memory.
// Build with WARP_DMEM_ARB_PRIORITY_EN defined to also exercise the preferred-warp search.
module tb_warp_dmem_arbiter;
   localparam int T  = 4;
   localparam int C  = 2;
   localparam int NC = 2 * T;
   localparam int AB = 8;
   localparam int DB = 8;

   logic clk = 1'b0;
   logic reset;
`ifdef WARP_DMEM_ARB_PRIORITY_EN
   logic priority_warp;
`endif

   int total = 0;
   int bad   = 0;

   logic [7:0]    memArr [256];
   int            rdCnt [C];
   int            wrCnt [C];
   logic [DB-1:0] lastData [NC];

   warp_dmem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .THREADS_PER_BLOCK(T), .NUM_CHANNELS(C)) bus ();

   warp_dmem_arbiter #(
      .ADDR_BITS(AB), .DATA_BITS(DB), .THREADS_PER_BLOCK(T), .NUM_CHANNELS(C)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
`ifdef WARP_DMEM_ARB_PRIORITY_EN
      ,
      .priority_warp(priority_warp)
`endif
   );

   always #5 clk = ~clk;

   // Data memory: answers the third negedge a request is seen, reads before writes.
   always @(negedge clk) begin
      for (int ch = 0; ch < C; ch++) begin
         bus.mem_read_ready[ch] = 1'b0;
         bus.mem_read_data[ch]  = '0;
         if (reset || !bus.mem_read_valid[ch]) rdCnt[ch] = 0;
         else begin
            rdCnt[ch]++;
            if (rdCnt[ch] == 3) begin
               bus.mem_read_ready[ch] = 1'b1;
               bus.mem_read_data[ch]  = memArr[bus.mem_read_address[ch]];
               rdCnt[ch] = 0;
            end
         end
      end
      for (int ch = 0; ch < C; ch++) begin
         bus.mem_write_ready[ch] = 1'b0;
         if (reset || !bus.mem_write_valid[ch]) wrCnt[ch] = 0;
         else begin
            wrCnt[ch]++;
            if (wrCnt[ch] == 3) begin
               bus.mem_write_ready[ch] = 1'b1;
               memArr[bus.mem_write_address[ch]] = bus.mem_write_data[ch];
               wrCnt[ch] = 0;
            end
         end
      end
   end

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      bus.consumer_read_valid    = '0;
      bus.consumer_read_address  = '0;
      bus.consumer_write_valid   = '0;
      bus.consumer_write_address = '0;
      bus.consumer_write_data    = '0;
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      waitCycle();
      reset = 1'b0;
   endtask

   // Acts as the LSUs: drops each valid once its ready is seen; ok=0 if the budget runs out.
   task automatic drainConsumers(input logic [NC-1:0] mask, output bit ok);
      logic [NC-1:0] seen;
      seen = '0;
      ok   = 1'b0;
      for (int cyc = 0; cyc < 60 && !ok; cyc++) begin
         waitCycle();
         for (int c = 0; c < NC; c++) begin
            if (bus.consumer_read_valid[c] && bus.consumer_read_ready[c]) begin
               lastData[c] = bus.consumer_read_data[c];
               bus.consumer_read_valid[c] = 1'b0;
               seen[c] = 1'b1;
            end
            if (bus.consumer_write_valid[c] && bus.consumer_write_ready[c]) begin
               bus.consumer_write_valid[c] = 1'b0;
               seen[c] = 1'b1;
            end
         end
         if ((seen & mask) == mask) ok = 1'b1;
      end
      if (ok) waitCycle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clearInputs();
      bus.consumer_read_valid[3] = 1'b1;
      repeat (2) waitCycle();
      total++; if (bus.mem_read_valid !== 2'b00) begin bad++; $display("[TB] FAIL reset_mem_read_valid: got=%b expected=00", bus.mem_read_valid); end
      total++; if (bus.mem_write_valid !== 2'b00) begin bad++; $display("[TB] FAIL reset_mem_write_valid: got=%b expected=00", bus.mem_write_valid); end
      total++; if (bus.mem_read_address !== 16'h0) begin bad++; $display("[TB] FAIL reset_mem_read_address: got=%h expected=0000", bus.mem_read_address); end
      total++; if ({bus.mem_write_address, bus.mem_write_data} !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_write_bus: got=%h expected=0", {bus.mem_write_address, bus.mem_write_data}); end
      total++; if (bus.consumer_read_ready !== 8'h00) begin bad++; $display("[TB] FAIL reset_read_ready: got=%h expected=00", bus.consumer_read_ready); end
      total++; if (bus.consumer_write_ready !== 8'h00) begin bad++; $display("[TB] FAIL reset_write_ready: got=%h expected=00", bus.consumer_write_ready); end
      total++; if (bus.consumer_read_data !== 64'h0) begin bad++; $display("[TB] FAIL reset_read_data: got=%h expected=0", bus.consumer_read_data); end
      bus.consumer_read_valid[3] = 1'b0;
      reset = 1'b0;
      waitCycle();
   endtask

   task automatic test_single_read();
      bit got;
      int lat;
      got = 1'b0;
      lat = 0;
      memArr[8'h12] = 8'hA5;
      bus.consumer_read_address[5] = 8'h12;
      bus.consumer_read_valid[5]   = 1'b1;
      waitCycle();
      total++; if (bus.mem_read_valid !== 2'b01) begin bad++; $display("[TB] FAIL single_mem_read_valid: got=%b expected=01", bus.mem_read_valid); end
      total++; if (bus.mem_read_address[0] !== 8'h12) begin bad++; $display("[TB] FAIL single_mem_read_address: got=%h expected=12", bus.mem_read_address[0]); end
      for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
         waitCycle();
         if (bus.consumer_read_ready[5]) begin
            got = 1'b1;
            lat = cyc;
         end
      end
      total++; if (!got || lat != 3) begin bad++; $display("[TB] FAIL single_ready_latency: got=%0d expected=3", got ? lat : -1); end
      total++; if (bus.consumer_read_data[5] !== 8'hA5) begin bad++; $display("[TB] FAIL single_read_data: got=%h expected=a5", bus.consumer_read_data[5]); end
      total++; if (bus.mem_read_valid !== 2'b00) begin bad++; $display("[TB] FAIL single_valid_cleared: got=%b expected=00", bus.mem_read_valid); end
      bus.consumer_read_valid[5] = 1'b0;
      waitCycle();
      total++; if (bus.consumer_read_ready !== 8'h00) begin bad++; $display("[TB] FAIL single_ready_drop: got=%h expected=00", bus.consumer_read_ready); end
      total++; if (bus.consumer_read_data[5] !== 8'hA5) begin bad++; $display("[TB] FAIL single_data_hold: got=%h expected=a5", bus.consumer_read_data[5]); end
   endtask

   task automatic test_saturation();
      int            order[$];
      logic [C-1:0]  prevValid;
      logic [NC-1:0] done;
      logic [7:0]    expData;
      int            gotIdx;
      prevValid = '0;
      done      = '0;
      pulseReset();
      for (int c = 0; c < NC; c++) begin
         memArr[8'h20 + 8'(c)] = 8'h50 + 8'(3 * c);
         bus.consumer_read_address[c] = 8'h20 + 8'(c);
      end
      bus.consumer_read_valid = 8'hFF;
      for (int cyc = 0; cyc < 200 && done != 8'hFF; cyc++) begin
         waitCycle();
         for (int ch = 0; ch < C; ch++)
            if (bus.mem_read_valid[ch] && !prevValid[ch]) order.push_back(int'(bus.mem_read_address[ch]) - 'h20);
         if (bus.mem_read_valid == 2'b11) begin
            total++; if (bus.mem_read_address[0] === bus.mem_read_address[1]) begin bad++; $display("[TB] FAIL sat_same_consumer: got=%h expected=distinct", bus.mem_read_address[0]); end
         end
         prevValid = bus.mem_read_valid;
         for (int c = 0; c < NC; c++) begin
            if (bus.consumer_read_valid[c] && bus.consumer_read_ready[c]) begin
               expData = 8'h50 + 8'(3 * c);
               total++; if (bus.consumer_read_data[c] !== expData) begin bad++; $display("[TB] FAIL sat_data_%0d: got=%h expected=%h", c, bus.consumer_read_data[c], expData); end
               bus.consumer_read_valid[c] = 1'b0;
               done[c] = 1'b1;
            end
         end
      end
      waitCycle();
      total++; if (done !== 8'hFF) begin bad++; $display("[TB] FAIL sat_all_ready: got=%h expected=ff", done); end
      for (int i = 0; i < NC; i++) begin
         gotIdx = (i < order.size()) ? order[i] : -1;
         total++; if (gotIdx != i) begin bad++; $display("[TB] FAIL sat_grant_order_%0d: got=%0d expected=%0d", i, gotIdx, i); end
      end
   endtask

   task automatic test_rw_mix();
      bit ok;
      memArr[8'h40] = 8'h77;
      bus.consumer_write_address[0] = 8'h40;
      bus.consumer_write_data[0]    = 8'h33;
      bus.consumer_write_valid[0]   = 1'b1;
      bus.consumer_read_address[4]  = 8'h40;
      bus.consumer_read_valid[4]    = 1'b1;
      waitCycle();
      total++; if (bus.mem_write_valid !== 2'b01) begin bad++; $display("[TB] FAIL mix_write_valid: got=%b expected=01", bus.mem_write_valid); end
      total++; if ({bus.mem_write_address[0], bus.mem_write_data[0]} !== 16'h4033) begin bad++; $display("[TB] FAIL mix_write_bus: got=%h expected=4033", {bus.mem_write_address[0], bus.mem_write_data[0]}); end
      total++; if (bus.mem_read_valid !== 2'b10) begin bad++; $display("[TB] FAIL mix_read_valid: got=%b expected=10", bus.mem_read_valid); end
      total++; if (bus.mem_read_address[1] !== 8'h40) begin bad++; $display("[TB] FAIL mix_read_address: got=%h expected=40", bus.mem_read_address[1]); end
      drainConsumers(8'h11, ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL mix_complete: got=timeout expected=both ready"); end
      total++; if (memArr[8'h40] !== 8'h33) begin bad++; $display("[TB] FAIL mix_mem_written: got=%h expected=33", memArr[8'h40]); end
      total++; if (lastData[4] !== 8'h77) begin bad++; $display("[TB] FAIL mix_read_data: got=%h expected=77", lastData[4]); end
      // consumer 2 asks for both: the read goes first, the write follows afterwards
      bus.consumer_read_address[2]  = 8'h41;
      bus.consumer_write_address[2] = 8'h42;
      bus.consumer_write_data[2]    = 8'h99;
      bus.consumer_read_valid[2]    = 1'b1;
      bus.consumer_write_valid[2]   = 1'b1;
      waitCycle();
      total++; if ({bus.mem_read_valid, bus.mem_write_valid} !== 4'b0100) begin bad++; $display("[TB] FAIL both_read_wins: got=%b expected=0100", {bus.mem_read_valid, bus.mem_write_valid}); end
      drainConsumers(8'h04, ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL both_read_complete: got=timeout expected=ready"); end
      drainConsumers(8'h04, ok);
      total++; if (!ok || memArr[8'h42] !== 8'h99) begin bad++; $display("[TB] FAIL both_write_complete: got=%h expected=99", memArr[8'h42]); end
   endtask

   task automatic test_reset_mid_read();
      bit ok;
      memArr[8'h05] = 8'h5C;
      bus.consumer_read_address[0] = 8'h05;
      bus.consumer_read_valid[0]   = 1'b1;
      waitCycle();
      total++; if (bus.mem_read_valid !== 2'b01) begin bad++; $display("[TB] FAIL midrst_granted: got=%b expected=01", bus.mem_read_valid); end
      reset = 1'b1;
      waitCycle();
      total++; if ({bus.mem_read_valid, bus.mem_read_address} !== 18'h0) begin bad++; $display("[TB] FAIL midrst_mem_read: got=%h expected=0", {bus.mem_read_valid, bus.mem_read_address}); end
      total++; if (bus.consumer_read_ready !== 8'h00) begin bad++; $display("[TB] FAIL midrst_ready: got=%h expected=00", bus.consumer_read_ready); end
      total++; if (bus.consumer_read_data !== 64'h0) begin bad++; $display("[TB] FAIL midrst_data: got=%h expected=0", bus.consumer_read_data); end
      reset = 1'b0;
      drainConsumers(8'h01, ok);
      total++; if (!ok || lastData[0] !== 8'h5C) begin bad++; $display("[TB] FAIL midrst_reread: got=%h expected=5c", lastData[0]); end
   endtask

   task automatic test_wrap();
      bit ok;
      memArr[8'h60] = 8'h66;
      bus.consumer_read_address[6] = 8'h60;
      bus.consumer_read_valid[6]   = 1'b1;
      drainConsumers(8'h40, ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL wrap_setup: got=timeout expected=ready"); end
      memArr[8'h70] = 8'h71;
      memArr[8'h01] = 8'h02;
      bus.consumer_read_address[7] = 8'h70;
      bus.consumer_read_address[0] = 8'h01;
      bus.consumer_read_valid[7]   = 1'b1;
      bus.consumer_read_valid[0]   = 1'b1;
      waitCycle();
      total++; if ({bus.mem_read_valid, bus.mem_read_address} !== 18'h3_0170) begin bad++; $display("[TB] FAIL wrap_grant: got=%h expected=30170", {bus.mem_read_valid, bus.mem_read_address}); end
      drainConsumers(8'h81, ok);
      total++; if (!ok || lastData[7] !== 8'h71 || lastData[0] !== 8'h02) begin bad++; $display("[TB] FAIL wrap_data: got=%h%h expected=7102", lastData[7], lastData[0]); end
      memArr[8'h11] = 8'h12;
      bus.consumer_read_address[1] = 8'h11;
      bus.consumer_read_valid[0]   = 1'b1;
      bus.consumer_read_valid[1]   = 1'b1;
      waitCycle();
      total++; if (bus.mem_read_address !== 16'h0111) begin bad++; $display("[TB] FAIL wrap_ptr_after: got=%h expected=0111", bus.mem_read_address); end
      drainConsumers(8'h03, ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL wrap_final: got=timeout expected=ready"); end
   endtask

`ifdef WARP_DMEM_ARB_PRIORITY_EN
   task automatic test_priority();
      bit ok;
      pulseReset();
      priority_warp = 1'b1;
      for (int c = 0; c < NC; c++) bus.consumer_read_address[c] = 8'h80 + 8'(c);
      bus.consumer_read_valid = 8'hFF;
      waitCycle();
      total++; if ({bus.mem_read_valid, bus.mem_read_address} !== 18'h3_8584) begin bad++; $display("[TB] FAIL prio_first_grants: got=%h expected=38584", {bus.mem_read_valid, bus.mem_read_address}); end
      drainConsumers(8'hFF, ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL prio_complete: got=timeout expected=all ready"); end
      priority_warp = 1'b0;
   endtask
`endif

   initial begin
      reset = 1'b1;
`ifdef WARP_DMEM_ARB_PRIORITY_EN
      priority_warp = 1'b0;
`endif
      for (int a = 0; a < 256; a++) memArr[a] = 8'h00;
      clearInputs();
      test_reset();
      test_single_read();
      test_saturation();
      test_rw_mix();
      test_reset_mid_read();
      test_wrap();
`ifdef WARP_DMEM_ARB_PRIORITY_EN
      test_priority();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
